sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one 16-bit SRAM controller port between three requesters:
//   - loader : 32-bit word writes, split into a low-half then a high-half write
//   - PPU    : byte reads
//   - CPU    : byte reads, and byte writes done as read-modify-write of a half
//
// Memory organisation: byte address a -> word a[16:2], half a[1], byte a[0].
// The low half of word w lives at {2'b00,w}; the high half at 18'h10000|w.
// Byte 0 is bits [7:0] of the half, byte 1 is bits [15:8].
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   load_req/addr/data/ack    loader word-write channel
//   ppu_req/addr/rdata/ack    PPU byte-read channel
//   cpu_req/wren/addr/wdata/rdata/ack   CPU byte read/write channel
//   mem_addr/wdata/rdata      half-word address and data to/from controller
//   mem_read/mem_write        registered access strobes (never both high)
//   mem_ready                 controller completion pulse
//   busy                      arbiter is not idle
//   timeout_err               sticky: an access exceeded READY_TIMEOUT cycles
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int READY_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_req,
    input  logic [14:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ack,
    input  logic        ppu_req,
    input  logic [16:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    output logic        ppu_ack,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic        busy,
    output logic        timeout_err
);

    // The timer only has to reach READY_TIMEOUT-1.
    localparam int TW = (READY_TIMEOUT > 2) ? $clog2(READY_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, LD_LO, GAP, LD_HI, RD, RMW_RD, RMW_WR, DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_LOAD, OWN_PPU, OWN_CPU
    } owner_t;

    state_t        state, state_d;
    owner_t        owner, owner_d;
    logic [14:0]   word, word_d;          // latched word address
    logic          half, half_d;          // latched half select
    logic          byte_sel, byte_sel_d;  // latched byte select
    logic [31:0]   data, data_d;          // load word, or CPU byte in [7:0]
    logic [15:0]   rmw_buf, rmw_buf_d;    // half read during CPU write
    logic          last_cpu, last_cpu_d;  // 1: CPU won the last PPU/CPU grant
    logic [TW-1:0] timer, timer_d;        // cycles the current strobe waited
    logic          timeout_err_d;
    logic [7:0]    ppu_rdata_d, cpu_rdata_d;
    logic [17:0]   mem_addr_d;
    logic [15:0]   mem_wdata_d;
    logic          mem_read_d, mem_write_d;
    logic          load_ack_d, ppu_ack_d, cpu_ack_d;
    logic [7:0]    rd_byte;

    assign busy    = (state != IDLE);
    assign rd_byte = byte_sel ? mem_rdata[15:8] : mem_rdata[7:0];

    // Next-state, next-latch and next-output logic. Strobes, address, data and
    // acks are computed from the *next* state so that their registers line up
    // with the state they belong to (strobe high the cycle after the grant).
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d       = state;
        owner_d       = owner;
        word_d        = word;
        half_d        = half;
        byte_sel_d    = byte_sel;
        data_d        = data;
        rmw_buf_d     = rmw_buf;
        last_cpu_d    = last_cpu;
        timer_d       = timer;
        timeout_err_d = timeout_err;
        ppu_rdata_d   = ppu_rdata;
        cpu_rdata_d   = cpu_rdata;

        case (state)
            IDLE: begin
                timer_d = '0;
                if (load_req) begin
                    owner_d = OWN_LOAD;
                    word_d  = load_addr;
                    data_d  = load_data;
                    state_d = LD_LO;
                end else if (ppu_req && (!cpu_req || last_cpu)) begin
                    owner_d    = OWN_PPU;
                    word_d     = ppu_addr[16:2];
                    half_d     = ppu_addr[1];
                    byte_sel_d = ppu_addr[0];
                    last_cpu_d = 1'b0;
                    state_d    = RD;
                end else if (cpu_req) begin
                    owner_d    = OWN_CPU;
                    word_d     = cpu_addr[16:2];
                    half_d     = cpu_addr[1];
                    byte_sel_d = cpu_addr[0];
                    data_d     = {24'h000000, cpu_wdata};
                    last_cpu_d = 1'b1;
                    state_d    = cpu_wren ? RMW_RD : RD;
                end
            end

            LD_LO, LD_HI, RD, RMW_RD, RMW_WR: begin
                if (mem_ready) begin
                    timer_d = '0;
                    case (state)
                        LD_LO:  state_d = GAP;
                        RMW_RD: begin
                            rmw_buf_d = mem_rdata;
                            state_d   = GAP;
                        end
                        RD: begin
                            if (owner == OWN_PPU) ppu_rdata_d = rd_byte;
                            else                  cpu_rdata_d = rd_byte;
                            state_d = DONE;
                        end
                        default: state_d = DONE;   // LD_HI, RMW_WR
                    endcase
                end else if (timer == TW'(READY_TIMEOUT - 1)) begin
                    // Controller never answered: abandon the access and still
                    // ack the owner so it is not left waiting forever.
                    timer_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end

            GAP:     state_d = (owner == OWN_LOAD) ? LD_HI : RMW_WR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs for the cycle after this edge.
        mem_read_d  = (state_d == RD) || (state_d == RMW_RD);
        mem_write_d = (state_d == LD_LO) || (state_d == LD_HI) || (state_d == RMW_WR);
        load_ack_d  = (state_d == DONE) && (owner_d == OWN_LOAD);
        ppu_ack_d   = (state_d == DONE) && (owner_d == OWN_PPU);
        cpu_ack_d   = (state_d == DONE) && (owner_d == OWN_CPU);

        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state_d)
            LD_LO: begin
                mem_addr_d  = {3'b000, word_d};
                mem_wdata_d = data_d[15:0];
            end
            LD_HI: begin
                mem_addr_d  = {1'b0, 1'b1, 1'b0, word_d};
                mem_wdata_d = data_d[31:16];
            end
            RD, RMW_RD: mem_addr_d = {1'b0, half_d, 1'b0, word_d};
            RMW_WR: begin
                mem_addr_d  = {1'b0, half_d, 1'b0, word_d};
                // Replace only the addressed byte; keep the other as read.
                mem_wdata_d = byte_sel_d ? {data_d[7:0], rmw_buf_d[7:0]}
                                         : {rmw_buf_d[15:8], data_d[7:0]};
            end
            default: ;
        endcase
    end

    // NOTE: reset is synchronous (sampled on the clock edge), and all state is
    // updated with non-blocking assignments so every register sees the values
    // from before the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_LOAD;
            word        <= '0;
            half        <= 1'b0;
            byte_sel    <= 1'b0;
            data        <= '0;
            rmw_buf     <= '0;
            last_cpu    <= 1'b1;   // PPU wins the first contested grant
            timer       <= '0;
            timeout_err <= 1'b0;
            ppu_rdata   <= 8'h00;
            cpu_rdata   <= 8'h00;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            load_ack    <= 1'b0;
            ppu_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            word        <= word_d;
            half        <= half_d;
            byte_sel    <= byte_sel_d;
            data        <= data_d;
            rmw_buf     <= rmw_buf_d;
            last_cpu    <= last_cpu_d;
            timer       <= timer_d;
            timeout_err <= timeout_err_d;
            ppu_rdata   <= ppu_rdata_d;
            cpu_rdata   <= cpu_rdata_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_read    <= mem_read_d;
            mem_write   <= mem_write_d;
            load_ack    <= load_ack_d;
            ppu_ack     <= ppu_ack_d;
            cpu_ack     <= cpu_ack_d;
        end
    end

endmodule
